// File: rtl/bp_core_lce_req_arb.sv
// rtl/bp_core_lce_req_arb.sv - N-channel LCE request concentrator with per-channel credits
//
// Buffers request messages from num_lce_p LCEs in small per-channel FIFOs and
// arbitrates them onto a single valid/ready network port through a one-entry
// output register. Each channel carries a credit counter that bounds its
// outstanding (accepted but not yet returned) requests.
//
// Ports:
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset (release expected synchronous)
//   lce_req_i        per-LCE request messages, channel i at [i*msg_width_p +: msg_width_p]
//   lce_req_v_i      per-LCE request valid
//   lce_req_yumi_o   per-LCE accept, combinational
//   credit_return_i  one credit returned to channel i this cycle
//   net_req_o        network request message
//   net_req_src_o    source channel of net_req_o
//   net_req_v_o      network request valid
//   net_req_ready_i  network ready
//   credits_full_o   channel has credits_p requests outstanding
//   credits_empty_o  channel has no requests outstanding
module bp_core_lce_req_arb #(
    parameter int num_lce_p   = 2,
    parameter int msg_width_p = 128,
    parameter int fifo_els_p  = 2,
    parameter int credits_p   = 8,
    parameter int arb_mode_p  = 0
) (
    input  logic                                           clk_i,
    input  logic                                           reset_n_i,
    input  logic [num_lce_p*msg_width_p-1:0]               lce_req_i,
    input  logic [num_lce_p-1:0]                           lce_req_v_i,
    output logic [num_lce_p-1:0]                           lce_req_yumi_o,
    input  logic [num_lce_p-1:0]                           credit_return_i,
    output logic [msg_width_p-1:0]                         net_req_o,
    output logic [((num_lce_p > 1) ? $clog2(num_lce_p) : 1)-1:0] net_req_src_o,
    output logic                                           net_req_v_o,
    input  logic                                           net_req_ready_i,
    output logic [num_lce_p-1:0]                           credits_full_o,
    output logic [num_lce_p-1:0]                           credits_empty_o
);

    localparam int src_w_lp  = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int ptr_w_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int fcnt_w_lp = $clog2(fifo_els_p + 1);
    localparam int ccnt_w_lp = $clog2(credits_p + 1);

    localparam logic [ptr_w_lp-1:0]  ptr_last_lp = ptr_w_lp'(fifo_els_p - 1);
    localparam logic [src_w_lp-1:0]  src_last_lp = src_w_lp'(num_lce_p - 1);
    localparam logic [fcnt_w_lp-1:0] fifo_max_lp = fcnt_w_lp'(fifo_els_p);
    localparam logic [ccnt_w_lp-1:0] cred_max_lp = ccnt_w_lp'(credits_p);

    // Per-channel FIFO storage and bookkeeping
    logic [msg_width_p-1:0] mem    [num_lce_p][fifo_els_p];
    logic [ptr_w_lp-1:0]    wr_ptr [num_lce_p];
    logic [ptr_w_lp-1:0]    rd_ptr [num_lce_p];
    logic [fcnt_w_lp-1:0]   fcnt   [num_lce_p];
    logic [ccnt_w_lp-1:0]   ccnt   [num_lce_p];

    logic [num_lce_p-1:0]   fifo_full;
    logic [num_lce_p-1:0]   fifo_empty;
    logic [num_lce_p-1:0]   yumi;
    logic [num_lce_p-1:0]   pop;
    logic [num_lce_p-1:0]   ret_eff;

    // Output register and arbitration state
    logic                   out_v;
    logic [msg_width_p-1:0] out_data;
    logic [src_w_lp-1:0]    out_src;
    logic [src_w_lp-1:0]    rr_ptr;

    logic                   load;
    logic                   grant_v;
    logic [src_w_lp-1:0]    grant_idx;
    logic [msg_width_p-1:0] head_data;
    int                     search_start;

    always_comb begin
        fifo_full       = '0;
        fifo_empty      = '0;
        yumi            = '0;
        ret_eff         = '0;
        credits_full_o  = '0;
        credits_empty_o = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            fifo_full[i]       = (fcnt[i] == fifo_max_lp);
            fifo_empty[i]      = (fcnt[i] == '0);
            // Gated by reset so the accept drops in the same cycle reset asserts.
            yumi[i]            = reset_n_i & lce_req_v_i[i] & ~fifo_full[i] & (ccnt[i] < cred_max_lp);
            // A return with nothing outstanding is dropped rather than wrapping the counter.
            ret_eff[i]         = credit_return_i[i] & (ccnt[i] != '0);
            credits_full_o[i]  = (ccnt[i] == cred_max_lp);
            credits_empty_o[i] = (ccnt[i] == '0);
        end
    end

    assign lce_req_yumi_o = yumi;

    // Output register can take a new entry when empty or draining this cycle.
    assign load         = ~out_v | net_req_ready_i;
    assign search_start = (arb_mode_p == 1) ? 0 : int'(rr_ptr);

    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < num_lce_p; k++) begin
            if (!grant_v && !fifo_empty[(search_start + k) % num_lce_p]) begin
                grant_v   = 1'b1;
                grant_idx = src_w_lp'((search_start + k) % num_lce_p);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            pop[i] = load & grant_v & (grant_idx == src_w_lp'(i));
        end
    end

    assign head_data = mem[grant_idx][rd_ptr[grant_idx]];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_lce_p; i++) begin
            if (yumi[i]) begin
                mem[i][wr_ptr[i]] <= lce_req_i[i*msg_width_p +: msg_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_lce_p; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fcnt[i]   <= '0;
                ccnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < num_lce_p; i++) begin
                if (yumi[i]) begin
                    wr_ptr[i] <= (wr_ptr[i] == ptr_last_lp) ? '0 : wr_ptr[i] + ptr_w_lp'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == ptr_last_lp) ? '0 : rd_ptr[i] + ptr_w_lp'(1);
                end
                case ({yumi[i], pop[i]})
                    2'b10:   fcnt[i] <= fcnt[i] + fcnt_w_lp'(1);
                    2'b01:   fcnt[i] <= fcnt[i] - fcnt_w_lp'(1);
                    default: fcnt[i] <= fcnt[i];
                endcase
                case ({yumi[i], ret_eff[i]})
                    2'b10:   ccnt[i] <= ccnt[i] + ccnt_w_lp'(1);
                    2'b01:   ccnt[i] <= ccnt[i] - ccnt_w_lp'(1);
                    default: ccnt[i] <= ccnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_v    <= 1'b0;
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            if (grant_v) begin
                out_v    <= 1'b1;
                out_data <= head_data;
                out_src  <= grant_idx;
                if (arb_mode_p == 0) begin
                    rr_ptr <= (grant_idx == src_last_lp) ? '0 : grant_idx + src_w_lp'(1);
                end
            end else begin
                out_v <= 1'b0;
            end
        end
    end

    assign net_req_v_o   = out_v;
    assign net_req_o     = out_data;
    assign net_req_src_o = out_src;

    for (genvar g = 0; g < num_lce_p; g++) begin : g_credit_chk
        always @(posedge clk_i) begin
            if (reset_n_i && credit_return_i[g]) begin
                assert (ccnt[g] != '0);
            end
        end
    end

endmodule

// File: tb/tb_bp_core_lce_req_arb.sv
// tb/tb_bp_core_lce_req_arb.sv - self-checking bench for bp_core_lce_req_arb (round-robin and fixed-priority)
module tb_bp_core_lce_req_arb;

    localparam int N = 2;
    localparam int W = 32;
    localparam int E = 2;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] req = '0;
    logic [N-1:0]   v = '0;
    logic [N-1:0]   ret = '0;
    logic           ready = 1'b0;

    logic [N-1:0]   y_o     [2];
    logic [W-1:0]   d_o     [2];
    logic           s_o     [2];
    logic           nv_o    [2];
    logic [N-1:0]   full_o  [2];
    logic [N-1:0]   empty_o [2];

    always #5 clk = ~clk;

    bp_core_lce_req_arb #(.num_lce_p(N), .msg_width_p(W), .fifo_els_p(E), .credits_p(C), .arb_mode_p(0)) dut_rr (
        .clk_i(clk), .reset_n_i(rst_n), .lce_req_i(req), .lce_req_v_i(v), .lce_req_yumi_o(y_o[0]),
        .credit_return_i(ret), .net_req_o(d_o[0]), .net_req_src_o(s_o[0]), .net_req_v_o(nv_o[0]),
        .net_req_ready_i(ready), .credits_full_o(full_o[0]), .credits_empty_o(empty_o[0]));

    bp_core_lce_req_arb #(.num_lce_p(N), .msg_width_p(W), .fifo_els_p(E), .credits_p(C), .arb_mode_p(1)) dut_fp (
        .clk_i(clk), .reset_n_i(rst_n), .lce_req_i(req), .lce_req_v_i(v), .lce_req_yumi_o(y_o[1]),
        .credit_return_i(ret), .net_req_o(d_o[1]), .net_req_src_o(s_o[1]), .net_req_v_o(nv_o[1]),
        .net_req_ready_i(ready), .credits_full_o(full_o[1]), .credits_empty_o(empty_o[1]));

    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", nm, d, act, exp);
        end
    endfunction

    // Reference model: index d*N+i holds channel i of model d (0 = round robin, 1 = fixed priority)
    logic [W-1:0] mq [2*N][$];
    int           mcnt [2*N];
    bit           mov [2];
    logic [W-1:0] mdat [2];
    int           msrc [2];
    int           mrr [2];

    function automatic void mreset();
        for (int k = 0; k < 2*N; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
        for (int d = 0; d < 2; d++) begin
            mov[d]  = 1'b0;
            mdat[d] = '0;
            msrc[d] = 0;
            mrr[d]  = 0;
        end
    endfunction

    function automatic logic [N-1:0] exp_y(int d);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            r[i] = rst_n && v[i] && (mq[d*N+i].size() < E) && (mcnt[d*N+i] < C);
        return r;
    endfunction

    function automatic void mstep(int d);
        logic [N-1:0] y;
        int g;
        int idx;
        int old;
        y = exp_y(d);
        if (!mov[d] || ready) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (d == 1) ? k : (mrr[d] + k) % N;
                if (g < 0 && mq[d*N+idx].size() > 0) g = idx;
            end
            if (g >= 0) begin
                mdat[d] = mq[d*N+g].pop_front();
                msrc[d] = g;
                mov[d]  = 1'b1;
                if (d == 0) mrr[d] = (g + 1) % N;
            end else begin
                mov[d] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (y[i]) mq[d*N+i].push_back(req[i*W +: W]);
            old = mcnt[d*N+i];
            mcnt[d*N+i] = old + int'(y[i]) - int'(ret[i] && old > 0);
        end
    endfunction

    always @(negedge rst_n) mreset();

    always @(posedge clk) begin
        if (!rst_n) mreset();
        else for (int d = 0; d < 2; d++) mstep(d);
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        logic [N-1:0] ef;
        logic [N-1:0] ee;
        for (int d = 0; d < 2; d++) begin
            ef = '0;
            ee = '0;
            for (int i = 0; i < N; i++) begin
                ef[i] = (mcnt[d*N+i] == C);
                ee[i] = (mcnt[d*N+i] == 0);
            end
            chk("yumi", d, 64'(y_o[d]), 64'(exp_y(d)));
            chk("net_v", d, 64'(nv_o[d]), 64'(mov[d]));
            if (mov[d]) begin
                chk("net_data", d, 64'(d_o[d]), 64'(mdat[d]));
                chk("net_src", d, 64'(s_o[d]), 64'(msrc[d]));
            end
            chk("cred_full", d, 64'(full_o[d]), 64'(ef));
            chk("cred_empty", d, 64'(empty_o[d]), 64'(ee));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_data();
        for (int i = 0; i < N; i++) req[i*W +: W] = $urandom;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        v     = '0;
        ret   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    int           src_rr [$];
    int           src_fp [$];
    logic [W-1:0] acc [$];
    logic [W-1:0] drained [$];
    logic [W-1:0] held;
    int           ycnt;

    initial begin
        // Reset state, with valids held high to show yumi stays low
        v = 2'b11;
        tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_net_v", d, 64'(nv_o[d]), 64'd0);
            chk("rst_net_data", d, 64'(d_o[d]), 64'd0);
            chk("rst_net_src", d, 64'(s_o[d]), 64'd0);
            chk("rst_yumi", d, 64'(y_o[d]), 64'd0);
            chk("rst_full", d, 64'(full_o[d]), 64'd0);
            chk("rst_empty", d, 64'(empty_o[d]), 64'h3);
        end

        // Both channels busy, ready high: RR alternates, fixed priority starves ch1
        do_reset();
        v = 2'b11;
        ready = 1'b1;
        new_data();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) chk("first_yumi", 0, 64'(y_o[0]), 64'h3);
            if (c < 2) chk("lat_no_valid", 0, 64'(nv_o[0]), 64'd0);
            if (c == 2) chk("lat_valid", 0, 64'(nv_o[0]), 64'd1);
            if (nv_o[0]) src_rr.push_back(int'(s_o[0]));
            if (nv_o[1]) src_fp.push_back(int'(s_o[1]));
            tick();
            new_data();
        end
        chk("rr_len", 0, 64'(src_rr.size() >= 4), 64'd1);
        if (src_rr.size() >= 4) begin
            chk("rr_seq0", 0, 64'(src_rr[0]), 64'd0);
            chk("rr_seq1", 0, 64'(src_rr[1]), 64'd1);
            chk("rr_seq2", 0, 64'(src_rr[2]), 64'd0);
            chk("rr_seq3", 0, 64'(src_rr[3]), 64'd1);
        end
        chk("fp_len", 1, 64'(src_fp.size() >= 9), 64'd1);
        if (src_fp.size() >= 9) begin
            ycnt = 0;
            for (int k = 0; k < 8; k++) if (src_fp[k] == 0) ycnt++;
            chk("fp_ch0_first8", 1, 64'(ycnt), 64'd8);
            chk("fp_ch1_after", 1, 64'(src_fp[8]), 64'd1);
        end

        // Channel 0 only, ready low: two FIFO entries plus the output register
        do_reset();
        v = 2'b01;
        ready = 1'b0;
        new_data();
        ycnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (y_o[0][0]) begin
                ycnt++;
                acc.push_back(req[W-1:0]);
            end
            if (c == 2) held = d_o[0];
            if (c > 2) chk("stall_stable", 0, 64'(d_o[0]), 64'(held));
            tick();
            new_data();
        end
        chk("stall_yumis", 0, 64'(ycnt), 64'd3);
        v = 2'b00;
        ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (nv_o[0]) drained.push_back(d_o[0]);
            tick();
        end
        chk("drain_count", 0, 64'(drained.size()), 64'd3);
        if (drained.size() == 3 && acc.size() == 3)
            for (int k = 0; k < 3; k++) chk("drain_order", 0, 64'(drained[k]), 64'(acc[k]));

        // Credit limit: eight accepts, then one more per returned credit
        do_reset();
        v = 2'b01;
        ready = 1'b1;
        ycnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (y_o[0][0]) ycnt++;
            tick();
            new_data();
        end
        chk("credit_yumis", 0, 64'(ycnt), 64'd8);
        @(negedge clk);
        chk("credit_full", 0, 64'(full_o[0]), 64'h1);
        tick();
        ret = 2'b01;
        @(negedge clk);
        chk("ret_cycle_yumi", 0, 64'(y_o[0][0]), 64'd0);
        tick();
        ret = 2'b00;
        @(negedge clk);
        chk("post_ret_yumi", 0, 64'(y_o[0][0]), 64'd1);
        tick();
        @(negedge clk);
        chk("refull_yumi", 0, 64'(y_o[0][0]), 64'd0);

        // Reset while the output register holds a message
        do_reset();
        v = 2'b11;
        ready = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("pre_rst_valid", 0, 64'(nv_o[0]), 64'd1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("midrst_net_v", d, 64'(nv_o[d]), 64'd0);
            chk("midrst_yumi", d, 64'(y_o[d]), 64'd0);
            chk("midrst_empty", d, 64'(empty_o[d]), 64'h3);
        end
        tick();
        rst_n = 1'b1;

        // Randomised traffic; credits returned only where both models have some outstanding
        for (int c = 0; c < 3000; c++) begin
            tick();
            new_data();
            v     = N'($urandom);
            ready = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++)
                ret[i] = (mcnt[i] > 0) && (mcnt[N+i] > 0) && ($urandom_range(2) == 0);
            rst_n = ($urandom_range(299) != 0);
            if (!rst_n) ret = '0;
        end
        tick();
        rst_n = 1'b1;
        v = '0;
        ret = '0;
        tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
